// File: rtl/rc4_stream_xor.sv
// RC4 keystream consumer: XORs buffered keystream onto a byte stream.
// Supports RC4-drop[N] discard of the first keystream bytes per session.
module rc4_stream_xor #(
    parameter int KS_DEPTH = 4,
    parameter int DROP_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sess_start,
    input  logic [DROP_W-1:0] cfg_drop,
    input  logic              ks_valid,
    input  logic [7:0]        ks_data,
    output logic              ks_ready,
    input  logic              din_valid,
    input  logic [7:0]        din_data,
    input  logic              din_last,
    output logic              din_ready,
    output logic              dout_valid,
    output logic [7:0]        dout_data,
    output logic              dout_last,
    input  logic              dout_ready,
    output logic              busy,
    output logic [15:0]       byte_cnt
);

    localparam int PW = $clog2(KS_DEPTH);

    typedef enum logic [1:0] {IDLE, DROP, RUN, LAST} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW:0]       cnt_q, cnt_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              dout_valid_q, dout_valid_d;
    logic [7:0]        dout_data_q, dout_data_d;
    logic              dout_last_q, dout_last_d;
    logic [15:0]       byte_cnt_q, byte_cnt_d;
    logic [7:0]        ks_mem_q [KS_DEPTH];

    logic fifo_full, fifo_ne;
    logic ks_hs, din_hs, dout_hs, push, pop;

    assign fifo_full = (cnt_q == (PW+1)'(KS_DEPTH));
    assign fifo_ne   = (cnt_q != '0);

    always_comb begin
        ks_ready  = 1'b0;
        din_ready = 1'b0;
        unique case (state_q)
            DROP: ks_ready = 1'b1;
            RUN: begin
                ks_ready  = !fifo_full;
                din_ready = fifo_ne && (!dout_valid_q || dout_ready);
            end
            default: ;
        endcase
    end

    assign ks_hs   = ks_valid && ks_ready;
    assign din_hs  = din_valid && din_ready;
    assign dout_hs = dout_valid_q && dout_ready;
    // Keystream taken during DROP is discarded, never buffered.
    assign push    = ks_hs && (state_q == RUN) && !sess_start;
    assign pop     = din_hs;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        drop_cnt_d   = drop_cnt_q;
        dout_valid_d = dout_valid_q;
        dout_data_d  = dout_data_q;
        dout_last_d  = dout_last_q;
        byte_cnt_d   = byte_cnt_q;

        unique case (state_q)
            DROP: begin
                if (ks_hs) begin
                    drop_cnt_d = drop_cnt_q - DROP_W'(1);
                    if (drop_cnt_q == DROP_W'(1)) state_d = RUN;
                end
            end
            RUN: begin
                if (din_hs && din_last) state_d = LAST;
            end
            LAST: begin
                if (dout_hs && dout_last_q) state_d = IDLE;
            end
            default: ;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);

        if (din_hs) begin
            dout_valid_d = 1'b1;
            dout_data_d  = din_data ^ ks_mem_q[rd_ptr_q];
            dout_last_d  = din_last;
            byte_cnt_d   = byte_cnt_q + 16'd1;
        end else if (dout_hs) begin
            dout_valid_d = 1'b0;
        end

        // A new session overrides every same-cycle event.
        if (sess_start) begin
            state_d      = (cfg_drop != '0) ? DROP : RUN;
            drop_cnt_d   = cfg_drop;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            cnt_d        = '0;
            dout_valid_d = 1'b0;
            dout_last_d  = 1'b0;
            dout_data_d  = dout_data_q;
            byte_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            drop_cnt_q   <= '0;
            dout_valid_q <= 1'b0;
            dout_data_q  <= '0;
            dout_last_q  <= 1'b0;
            byte_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            dout_valid_q <= dout_valid_d;
            dout_data_q  <= dout_data_d;
            dout_last_q  <= dout_last_d;
            byte_cnt_q   <= byte_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) ks_mem_q[wr_ptr_q] <= ks_data;
    end

    assign dout_valid = dout_valid_q;
    assign dout_data  = dout_data_q;
    assign dout_last  = dout_last_q;
    assign busy       = (state_q != IDLE);
    assign byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_rc4_stream_xor.sv
// Bench for rc4_stream_xor: directed sessions plus a long random-stall
// stream, checked against a keystream/expected-output scoreboard.
module tb_rc4_stream_xor;

    logic       clk;
    logic       rst_n;
    logic       sess_start;
    logic [9:0] cfg_drop;
    logic       ks_valid;
    logic [7:0] ks_data;
    logic       ks_ready;
    logic       din_valid;
    logic [7:0] din_data;
    logic       din_last;
    logic       din_ready;
    logic       dout_valid;
    logic [7:0] dout_data;
    logic       dout_last;
    logic       dout_ready;
    logic       busy;
    logic [15:0] byte_cnt;

    rc4_stream_xor #(.KS_DEPTH(4), .DROP_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .sess_start(sess_start),
        .cfg_drop(cfg_drop), .ks_valid(ks_valid), .ks_data(ks_data),
        .ks_ready(ks_ready), .din_valid(din_valid), .din_data(din_data),
        .din_last(din_last), .din_ready(din_ready),
        .dout_valid(dout_valid), .dout_data(dout_data),
        .dout_last(dout_last), .dout_ready(dout_ready),
        .busy(busy), .byte_cnt(byte_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  ksq[$];
    logic [8:0]  expq[$];
    logic [8:0]  got[$];
    logic [7:0]  ks_src[$];
    logic [8:0]  din_src[$];
    int          drop_left = 0;
    logic [15:0] exp_cnt = '0;
    logic        hs_ks, hs_din, hs_dout;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just before each rising edge, when all handshake inputs are stable.
    task automatic sample();
        hs_ks = 1'b0;
        hs_din = 1'b0;
        hs_dout = 1'b0;
        if (!rst_n || sess_start) begin
            ksq.delete();
            expq.delete();
            got.delete();
            exp_cnt = '0;
            drop_left = (!rst_n) ? 0 : int'(cfg_drop);
        end else begin
            hs_ks   = ks_valid && ks_ready;
            hs_din  = din_valid && din_ready;
            hs_dout = dout_valid && dout_ready;
            if (hs_dout) begin
                got.push_back({dout_last, dout_data});
                if (expq.size() == 0)
                    chk("dout_unexpected", 32'(expq.size()), 1);
                else
                    chk("dout_byte", {dout_last, dout_data}, expq.pop_front());
            end
            if (hs_din) begin
                if (ksq.size() == 0)
                    chk("ks_underflow", 32'(ksq.size()), 1);
                else begin
                    expq.push_back({din_last, din_data ^ ksq.pop_front()});
                    exp_cnt++;
                end
            end
            if (hs_ks) begin
                if (drop_left > 0) drop_left--;
                else ksq.push_back(ks_data);
            end
        end
    endtask

    task automatic step();
        #4;
        sample();
        @(negedge clk);
    endtask

    task automatic start(input logic [9:0] drop);
        sess_start = 1'b1;
        cfg_drop = drop;
        step();
        sess_start = 1'b0;
    endtask

    task automatic stream(input int budget, input int stall_pct);
        int n = 0;
        while (n < budget) begin
            if (!ks_valid && ks_src.size() > 0 &&
                $urandom_range(0, 99) >= stall_pct) begin
                ks_valid = 1'b1;
                ks_data = ks_src[0];
            end
            if (!din_valid && din_src.size() > 0 &&
                $urandom_range(0, 99) >= stall_pct) begin
                din_valid = 1'b1;
                {din_last, din_data} = din_src[0];
            end
            dout_ready = ($urandom_range(0, 99) >= stall_pct);
            step();
            if (hs_ks) begin
                void'(ks_src.pop_front());
                ks_valid = 1'b0;
            end
            if (hs_din) begin
                void'(din_src.pop_front());
                din_valid = 1'b0;
            end
            n++;
            if (din_src.size() == 0 && expq.size() == 0 && !busy) break;
        end
        if (n >= budget) chk("stream_timeout", 32'(n), 32'(budget - 1));
        ks_valid = 1'b0;
        din_valid = 1'b0;
    endtask

    initial begin
        logic [8:0] t1exp [3];
        logic [7:0] t2ks [4];
        t1exp = '{9'h0BB, 9'h099, 9'h1FF};
        t2ks  = '{8'h01, 8'h02, 8'h03, 8'h44};
        rst_n = 1'b0;
        sess_start = 1'b0;
        cfg_drop = '0;
        ks_valid = 1'b0;
        ks_data = '0;
        din_valid = 1'b0;
        din_data = '0;
        din_last = 1'b0;
        dout_ready = 1'b0;
        @(negedge clk);
        step();
        step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_dout_valid", 32'(dout_valid), 0);
        chk("rst_dout_data", 32'(dout_data), 0);
        chk("rst_dout_last", 32'(dout_last), 0);
        chk("rst_byte_cnt", 32'(byte_cnt), 0);
        chk("rst_ks_ready", 32'(ks_ready), 0);
        chk("rst_din_ready", 32'(din_ready), 0);
        rst_n = 1'b1;
        step();

        // T1: no drop, three-byte frame
        start(10'd0);
        ks_src = '{8'h11, 8'h22, 8'h33};
        din_src = '{9'h0AA, 9'h0BB, 9'h1CC};
        stream(200, 0);
        chk("t1_got_n", 32'(got.size()), 3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            chk("t1_got", 32'(got[i]), 32'(t1exp[i]));
        chk("t1_byte_cnt", 32'(byte_cnt), 3);
        chk("t1_busy", 32'(busy), 0);

        // T2: drop three keystream bytes
        start(10'd3);
        din_valid = 1'b1;
        din_data = 8'h44;
        din_last = 1'b1;
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ks_valid = 1'b1;
            ks_data = t2ks[i];
            chk("t2_din_wait", 32'(din_ready), 0);
            step();
        end
        ks_valid = 1'b0;
        chk("t2_din_ready", 32'(din_ready), 1);
        step();
        din_valid = 1'b0;
        chk("t2_dout_valid", 32'(dout_valid), 1);
        chk("t2_dout_data", 32'(dout_data), 32'h00);
        chk("t2_dout_last", 32'(dout_last), 1);
        step();
        chk("t2_busy", 32'(busy), 0);

        // T3: downstream stall while keystream keeps arriving
        start(10'd0);
        ks_valid = 1'b1;
        ks_data = 8'h50;
        din_valid = 1'b1;
        din_data = 8'h0F;
        din_last = 1'b0;
        dout_ready = 1'b0;
        repeat (3) begin
            step();
            if (hs_ks) ks_data++;
            if (hs_din) din_data++;
        end
        repeat (5) begin
            chk("t3_dout_valid", 32'(dout_valid), 1);
            chk("t3_dout_hold", 32'(dout_data), 32'h5F);
            chk("t3_din_ready", 32'(din_ready), 0);
            step();
            if (hs_ks) ks_data++;
            if (hs_din) din_data++;
        end
        chk("t3_ks_ready", 32'(ks_ready), 0);

        // T4: restart mid-frame with a drop count
        dout_ready = 1'b1;
        step();
        chk("t4_second_byte", 32'(hs_din), 1);
        ks_valid = 1'b0;
        din_valid = 1'b0;
        start(10'd2);
        chk("t4_dout_valid", 32'(dout_valid), 0);
        chk("t4_byte_cnt", 32'(byte_cnt), 0);
        chk("t4_ks_ready", 32'(ks_ready), 1);
        chk("t4_din_ready", 32'(din_ready), 0);
        ks_src = '{8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hB3};
        din_src = '{9'h010, 9'h020, 9'h130};
        stream(200, 0);
        chk("t4_got_last", 32'(got.size() == 3 ? got[2] : 9'h0), 32'h1_83);
        chk("t4_byte_cnt_end", 32'(byte_cnt), 3);

        // T5: reset pulse mid-RUN
        start(10'd0);
        ks_valid = 1'b1;
        ks_data = 8'h70;
        din_valid = 1'b1;
        din_data = 8'h01;
        din_last = 1'b0;
        dout_ready = 1'b1;
        repeat (3) begin
            step();
            if (hs_ks) ks_data++;
            if (hs_din) din_data++;
        end
        rst_n = 1'b0;
        ks_valid = 1'b0;
        din_valid = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_dout_valid", 32'(dout_valid), 0);
        chk("t5_dout_data", 32'(dout_data), 0);
        chk("t5_byte_cnt", 32'(byte_cnt), 0);
        chk("t5_ks_ready", 32'(ks_ready), 0);
        chk("t5_din_ready", 32'(din_ready), 0);
        start(10'd0);
        ks_src = '{8'h5A, 8'hC3};
        din_src = '{9'h0FF, 9'h100};
        stream(200, 0);
        chk("t5_byte_cnt_end", 32'(byte_cnt), 2);

        // T6: long frame with random stalls, counter wrap
        start(10'd0);
        for (int i = 0; i < 70000; i++) begin
            ks_src.push_back(8'($urandom));
            din_src.push_back({(i == 69999), 8'($urandom)});
        end
        stream(90000, 2);
        chk("t6_byte_cnt", 32'(byte_cnt), 32'(exp_cnt));
        chk("t6_byte_wrap", 32'(byte_cnt), 4464);
        chk("t6_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
